// File: rtl/lif_neuron_multi.sv
// rtl/lif_neuron_multi.sv - multi-input leaky integrate-and-fire neuron with refractory dwell and spike counter
// Optional adaptive threshold: define LIF_NEURON_ADAPTIVE_THRESHOLD_EN.
module lif_neuron_multi #(
  parameter int W            = 10,
  parameter int N_INPUTS     = 4,
  parameter int BASE         = 100,
  parameter int THRESHOLD    = 500,
  parameter int GAIN_SHIFT   = 5,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_SHIFT = 5,
  parameter int REFRAC_MIN   = 8,
  parameter int ADAPT_STEP   = 32,
  parameter int ADAPT_SHIFT  = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Clear,
  input  logic [N_INPUTS-1:0] i_Spikes,
  output logic [W-1:0]        o_Potential,
  output logic [W-1:0]        o_Threshold,
  output logic                o_Spike,
  output logic                o_Refractory,
  output logic [15:0]         o_Spike_Count
);

  localparam int KW = $clog2(N_INPUTS + 1);
  // Integration sum is wide enough to hold V plus N full increments before clamping
  localparam int SW = W + $clog2(N_INPUTS) + 1;
  localparam logic [W-1:0] VMAX   = '1;
  localparam logic [W-1:0] BASE_V = W'(BASE);
  localparam logic [W-1:0] THR_V  = W'(THRESHOLD);

  typedef enum logic {FREE, REFRACTORY} state_t;

  state_t         state, state_next;
  logic [W-1:0]   v, v_next;
  logic           spike_next;
  logic [15:0]    count, count_next;
  logic [7:0]     rcnt, rcnt_next;
  logic [W-1:0]   thr;
  logic [KW-1:0]  k;
  logic [W-1:0]   gain, leak, rdecay, diff;
  logic [SW-1:0]  sum;
  logic [W-1:0]   v_int, v_leak, v_ref;

  // Popcount of the input spike lines
  always_comb begin
    k = '0;
    for (int i = 0; i < N_INPUTS; i++) k = k + KW'(i_Spikes[i]);
  end

  // Candidate potentials: integrate (clamped), idle leak and refractory decay, each floored at BASE
  always_comb begin
    gain   = ((v >> GAIN_SHIFT) == '0) ? W'(1) : (v >> GAIN_SHIFT);
    diff   = v - BASE_V;
    leak   = ((diff >> LEAK_SHIFT) == '0) ? W'(1) : (diff >> LEAK_SHIFT);
    rdecay = ((v >> REFRAC_SHIFT) == '0) ? W'(1) : (v >> REFRAC_SHIFT);
    sum    = SW'(v) + SW'(k) * SW'(gain);
    v_int  = (sum > SW'(VMAX)) ? VMAX : sum[W-1:0];
    v_leak = (diff > leak) ? (v - leak) : BASE_V;
    v_ref  = (diff > rdecay) ? (v - rdecay) : BASE_V;
  end

  // Next-state and datapath decisions, all based on registered values
  always_comb begin
    state_next = state;
    v_next     = v;
    spike_next = 1'b0;
    count_next = count;
    rcnt_next  = rcnt;
    if (i_Clear) begin
      state_next = FREE;
      v_next     = BASE_V;
      rcnt_next  = 8'd0;
    end else if (state == FREE) begin
      if (v >= thr) begin
        spike_next = 1'b1;
        state_next = REFRACTORY;
        rcnt_next  = 8'(REFRAC_MIN);
        count_next = count + 16'd1;
      end else if (k != '0) begin
        v_next = v_int;
      end else if (v > BASE_V) begin
        v_next = v_leak;
      end
    end else begin
      if (rcnt != 8'd0) rcnt_next = rcnt - 8'd1;
      if (v > BASE_V) v_next = v_ref;
      if (v == BASE_V && rcnt == 8'd0) state_next = FREE;
    end
  end

  // State, potential, pulse, counters
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= FREE;
      v     <= BASE_V;
      o_Spike <= 1'b0;
      count <= 16'd0;
      rcnt  <= 8'd0;
    end else begin
      state <= state_next;
      v     <= v_next;
      o_Spike <= spike_next;
      count <= count_next;
      rcnt  <= rcnt_next;
    end
  end

`ifdef LIF_NEURON_ADAPTIVE_THRESHOLD_EN
  logic [ADAPT_SHIFT-1:0] tick_cnt, tick_next;
  logic [W-1:0]           thr_next;
  logic [W:0]             thr_up;

  // Threshold rises on fire (saturating) and relaxes toward THRESHOLD on each tick in FREE
  always_comb begin
    thr_next  = thr;
    tick_next = tick_cnt;
    thr_up    = {1'b0, thr} + (W+1)'(ADAPT_STEP);
    if (state == FREE) begin
      tick_next = tick_cnt + 1'b1;
      if (!i_Clear) begin
        if (v >= thr) thr_next = (thr_up > {1'b0, VMAX}) ? VMAX : thr_up[W-1:0];
        else if (tick_cnt == '1 && thr > THR_V) thr_next = thr - W'(1);
      end
    end
  end

  // Adaptive threshold and tick counter registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      thr      <= THR_V;
      tick_cnt <= '0;
    end else begin
      thr      <= thr_next;
      tick_cnt <= tick_next;
    end
  end
`else
  assign thr = THR_V;
`endif

  assign o_Potential   = v;
  assign o_Threshold   = thr;
  assign o_Refractory  = (state == REFRACTORY);
  assign o_Spike_Count = count;

endmodule

// File: tb/tb_lif_neuron_multi.sv
// tb/tb_lif_neuron_multi.sv - scoreboard bench for lif_neuron_multi with directed vectors
module tb_lif_neuron_multi;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [3:0]  spikes;
  logic [9:0]  pot, thr;
  logic        spk, refr;
  logic [15:0] cnt;

  logic [3:0]  sat_spikes;
  logic [9:0]  sat_pot, sat_thr;
  logic        sat_spk, sat_refr;
  logic [15:0] sat_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [9:0]  v;
    logic        spk;
    logic        refr;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  int ramp [15] = '{112, 124, 136, 152, 168, 188, 208, 232, 260, 292, 328, 368, 412, 460, 516};

  lif_neuron_multi dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clear), .i_Spikes(spikes),
    .o_Potential(pot), .o_Threshold(thr), .o_Spike(spk),
    .o_Refractory(refr), .o_Spike_Count(cnt)
  );

  lif_neuron_multi #(.THRESHOLD(1023)) dut_sat (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(1'b0), .i_Spikes(sat_spikes),
    .o_Potential(sat_pot), .o_Threshold(sat_thr), .o_Spike(sat_spk),
    .o_Refractory(sat_refr), .o_Spike_Count(sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: one expected record per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, " V"}, int'(pot), int'(e.v));
        check({e.name, " spike"}, int'(spk), int'(e.spk));
        check({e.name, " refr"}, int'(refr), int'(e.refr));
        check({e.name, " count"}, int'(cnt), int'(e.cnt));
        check({e.name, " thr"}, int'(thr), 500);
      end
    end
  end

  task automatic step(input logic [3:0] s, input logic c, input int ev, input logic es,
                      input logic er, input int ec, input string nm);
    exp_t e;
    @(negedge clk);
    spikes = s;
    clear  = c;
    e.name = nm; e.v = 10'(ev); e.spk = es; e.refr = er; e.cnt = 16'(ec);
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard drained", q.size(), 0);
  endtask

  task automatic ramp_to_fire(input int cnt_before);
    for (int i = 0; i < 15; i++) step(4'b1111, 1'b0, ramp[i], 1'b0, 1'b0, cnt_before, "ramp");
    step(4'b1111, 1'b0, 516, 1'b1, 1'b1, cnt_before + 1, "fire");
    step(4'b1111, 1'b0, 500, 1'b0, 1'b1, cnt_before + 1, "refr decay1");
  endtask

  initial begin
    int  dwell;
    int  prev;
    bit  mono_ok, spike_seen, exited;
    rst_n = 1'b0; clear = 1'b0; spikes = 4'b0000; sat_spikes = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset V", pot, 100);
    check("reset thr", thr, 500);
    check("reset spike", spk, 0);
    check("reset refr", refr, 0);
    check("reset count", cnt, 0);

    step(4'b0001, 1'b0, 103, 1'b0, 1'b0, 0, "single spike");
    step(4'b0000, 1'b0, 102, 1'b0, 1'b0, 0, "leak1");
    step(4'b0000, 1'b0, 101, 1'b0, 1'b0, 0, "leak2");
    step(4'b0000, 1'b0, 100, 1'b0, 1'b0, 0, "leak3");
    step(4'b0000, 1'b0, 100, 1'b0, 1'b0, 0, "rest hold1");
    step(4'b0000, 1'b0, 100, 1'b0, 1'b0, 0, "rest hold2");
    step(4'b1111, 1'b0, 112, 1'b0, 1'b0, 0, "multi 1111");
    step(4'b0101, 1'b0, 118, 1'b0, 1'b0, 0, "multi 0101");
    step(4'b0000, 1'b0, 117, 1'b0, 1'b0, 0, "leak from 118");
    step(4'b1111, 1'b1, 100, 1'b0, 1'b0, 0, "clear in FREE");

    ramp_to_fire(0);
    step(4'b1111, 1'b0, 485, 1'b0, 1'b1, 1, "refr decay2");
    step(4'b1111, 1'b0, 470, 1'b0, 1'b1, 1, "refr decay3");
    drain();

    dwell = 3; prev = 470; mono_ok = 1'b1; spike_seen = 1'b0; exited = 1'b0;
    for (int i = 0; i < 300 && !exited; i++) begin
      @(posedge clk);
      #1;
      if (!refr) exited = 1'b1;
      else begin
        dwell++;
        if (int'(pot) > prev) mono_ok = 1'b0;
        if (spk) spike_seen = 1'b1;
        prev = int'(pot);
      end
    end
    check("refractory exit within bound", int'(exited), 1);
    check("refractory V non-increasing", int'(mono_ok), 1);
    check("no spike in refractory", int'(spike_seen), 0);
    check("dwell at least 8", int'(dwell >= 8), 1);
    check("V at refractory exit", pot, 100);
    check("count after first fire", cnt, 1);

    ramp_to_fire(1);
    step(4'b1111, 1'b1, 100, 1'b0, 1'b0, 2, "clear mid refractory");
    ramp_to_fire(2);
    drain();
    check("refr before async reset", refr, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset V", pot, 100);
    check("async reset thr", thr, 500);
    check("async reset spike", spk, 0);
    check("async reset refr", refr, 0);
    check("async reset count", cnt, 0);

    @(negedge clk);
    rst_n = 1'b1;
    spikes = 4'b0000;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      sat_spikes = 4'b1111;
      @(posedge clk);
      #1;
      if (i == 19) check("sat pre-clamp V", sat_pot, 920);
      if (i == 20) check("sat clamp V", sat_pot, 1023);
    end
    @(posedge clk);
    #1;
    check("sat fire spike", sat_spk, 1);
    check("sat fire V held", sat_pot, 1023);
    check("sat fire count", sat_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
